// File: rtl/wb_camara_pkg.sv
// Shared definitions for the wb_camara capture block: register word
// offsets, capture FSM states and the pixel format conversion.
package wb_camara_pkg;

  // Word index of each register (byte address bits [3:2]).
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_PIXCNT  = 2'd2;
  localparam logic [1:0] REG_LINECNT = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    DONE
  } cam_state_t;

  // RGB565 arrives as two bytes, high byte first:
  //   hi = R[4:0] G[5:3], lo = G[2:0] B[4:0]
  // RGB332 keeps R[4:2], G[5:3], B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    logic unused_low_bits;
    unused_low_bits = ^{hi[4:3], lo[7:5], lo[2:0]};
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/wb_camara_if.sv
// Classic Wishbone slave bus bundle for the camera controller.
interface wb_camara_if;

  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/wb_camara_cam_sync.sv
// Camera port conditioning: 2-flop synchronizers for pclk/href/vsync,
// edge detection in the clk domain, and a data pipeline kept in step
// with the synchronized pclk so the byte is stable when the edge fires.
module cam_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       pclk,
  input  logic       href,
  input  logic       vsync,
  input  logic [7:0] cam_data,
  output logic       pclk_rise,
  output logic       href_s,
  output logic       href_fall,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic [7:0] data_s
);

  logic       pclk_m, pclk_s, pclk_d;
  logic       href_m, href_d;
  logic       vsync_m, vsync_s, vsync_d;
  logic [7:0] data_m;

  // First synchronizer stage; cam_data is captured alongside pclk so
  // both travel through the same number of registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_m  <= 1'b0;
      href_m  <= 1'b0;
      vsync_m <= 1'b0;
      data_m  <= '0;
    end else begin
      pclk_m  <= pclk;
      href_m  <= href;
      vsync_m <= vsync;
      data_m  <= cam_data;
    end
  end

  // Second synchronizer stage plus one-cycle history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_s  <= 1'b0;
      pclk_d  <= 1'b0;
      href_s  <= 1'b0;
      href_d  <= 1'b0;
      vsync_s <= 1'b0;
      vsync_d <= 1'b0;
      data_s  <= '0;
    end else begin
      pclk_s  <= pclk_m;
      pclk_d  <= pclk_s;
      href_s  <= href_m;
      href_d  <= href_s;
      vsync_s <= vsync_m;
      vsync_d <= vsync_s;
      data_s  <= data_m;
    end
  end

  assign pclk_rise  = pclk_s & ~pclk_d;
  assign href_fall  = ~href_s & href_d;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign vsync_fall = ~vsync_s & vsync_d;

endmodule

// File: rtl/wb_camara_ctrl.sv
// Wishbone-controlled single-frame camera capture. Assembles RGB565
// byte pairs into RGB332 pixels and writes them to a frame buffer.
module wb_camara_ctrl
  import wb_camara_pkg::*;
#(
  parameter int AW         = 15,
  parameter int MAX_PIXELS = 19200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pclk,
  input  logic          href,
  input  logic          vsync,
  input  logic [7:0]    cam_data,
  wb_camara_if.slave    wb,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          done_o
);

  localparam int             PW      = $clog2(MAX_PIXELS + 1);
  localparam logic [PW-1:0]  PIX_MAX = PW'(MAX_PIXELS);

  logic          pclk_rise, href_s, href_fall, vsync_rise, vsync_fall;
  logic [7:0]    data_s;

  cam_state_t    state, state_nxt;
  logic          phase;
  logic [7:0]    byte_hi;
  logic [PW-1:0] pixcnt;
  logic [15:0]   linecnt;

  logic          wb_req, start_wr, start_acc, enter_done;
  logic          busy, pix_limit, pix_evt, pix_wr;
  logic [31:0]   rd_data;
  logic          unused_bus_bits;

  cam_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .pclk       (pclk),
    .href       (href),
    .vsync      (vsync),
    .cam_data   (cam_data),
    .pclk_rise  (pclk_rise),
    .href_s     (href_s),
    .href_fall  (href_fall),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .data_s     (data_s)
  );

  // A request is serviced on the edge that raises ack; a held strobe
  // is therefore serviced every other cycle.
  assign wb_req   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign start_wr = wb_req & wb.wb_we_i & wb.wb_sel_i &
                    (wb.wb_adr_i[3:2] == REG_CTRL) & wb.wb_dat_i[0];

  assign busy      = (state == WAIT_VS) || (state == CAPTURE);
  assign pix_limit = (pixcnt == PIX_MAX);
  assign pix_evt   = pclk_rise & href_s & phase;
  assign pix_wr    = (state == CAPTURE) & pix_evt & ~pix_limit;

  assign unused_bus_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                             wb.wb_dat_i[31:1]};

  // Register read multiplexer.
  always_comb begin
    rd_data = '0;
    case (wb.wb_adr_i[3:2])
      REG_STATUS:  rd_data = {30'd0, done_o, busy};
      REG_CTRL:    rd_data = '0;
      REG_PIXCNT:  rd_data = 32'(pixcnt);
      REG_LINECNT: rd_data = 32'(linecnt);
      default:     rd_data = '0;
    endcase
  end

  // Wishbone acknowledge and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= wb_req;
      if (wb_req) begin
        wb.wb_dat_o <= rd_data;
      end
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture FSM next-state logic. Start is only honoured in IDLE/DONE,
  // so a start arriving while CAPTURE is finishing is simply dropped.
  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_wr) begin
          state_nxt = WAIT_VS;
          start_acc = 1'b1;
        end
      end
      WAIT_VS: begin
        if (vsync_fall) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vsync_rise || pix_limit) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte pairing: phase restarts at every line, first byte is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= 1'b0;
      byte_hi <= '0;
    end else if (!href_s) begin
      phase <= 1'b0;
    end else if (pclk_rise) begin
      phase <= ~phase;
      if (!phase) begin
        byte_hi <= data_s;
      end
    end
  end

  // Frame-buffer write port; address is the pixel count before increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= pix_wr;
      if (pix_wr) begin
        mem_addr <= AW'(pixcnt);
        mem_data <= rgb565_to_rgb332(byte_hi, data_s);
      end
    end
  end

  // Pixel and line counters, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixcnt  <= '0;
      linecnt <= '0;
    end else if (start_acc) begin
      pixcnt  <= '0;
      linecnt <= '0;
    end else begin
      if (pix_wr) begin
        pixcnt <= pixcnt + PW'(1);
      end
      if ((state == CAPTURE) && href_fall) begin
        linecnt <= linecnt + 16'd1;
      end
    end
  end

  // Done flag: set on frame completion, cleared by the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_o <= 1'b0;
    end else if (start_acc) begin
      done_o <= 1'b0;
    end else if (enter_done) begin
      done_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_camara_ctrl.sv
// Bench for wb_camara_ctrl: two instances (default limit and a 4-pixel
// limit) share the camera port; a frame-level model predicts writes
// and register contents.
module tb_wb_camara_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pclk = 1'b0;
  logic        href = 1'b0;
  logic        vsync = 1'b1;
  logic [7:0]  cam_data = 8'h00;

  wb_camara_if wb_a ();
  wb_camara_if wb_b ();

  logic [14:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic        we_a, we_b, done_a, done_b;

  always #5 clk = ~clk;

  wb_camara_ctrl #(.AW(15), .MAX_PIXELS(19200)) dut_a (
    .clk(clk), .rst(rst), .pclk(pclk), .href(href), .vsync(vsync),
    .cam_data(cam_data), .wb(wb_a.slave),
    .mem_addr(addr_a), .mem_data(data_a), .mem_we(we_a), .done_o(done_a)
  );

  wb_camara_ctrl #(.AW(15), .MAX_PIXELS(4)) dut_b (
    .clk(clk), .rst(rst), .pclk(pclk), .href(href), .vsync(vsync),
    .cam_data(cam_data), .wb(wb_b.slave),
    .mem_addr(addr_b), .mem_data(data_b), .mem_we(we_b), .done_o(done_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int          m_max [2] = '{19200, 4};
  bit          m_wait [2];
  bit          m_cap [2];
  bit          m_done [2];
  int          m_pix [2];
  int          m_lines [2];
  logic [22:0] q_a [$];
  logic [22:0] q_b [$];

  function automatic logic [7:0] to332(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    {r, g, b} = p;
    return {r[4:2], g[5:3], b[4:3]};
  endfunction

  function automatic logic [31:0] exp_status(input int d);
    return {30'd0, m_done[d], m_wait[d] | m_cap[d]};
  endfunction

  task automatic m_start(input int d);
    if (!(m_wait[d] || m_cap[d])) begin
      m_wait[d]  = 1'b1;
      m_done[d]  = 1'b0;
      m_pix[d]   = 0;
      m_lines[d] = 0;
    end
  endtask

  task automatic m_pixel(input logic [15:0] p);
    for (int d = 0; d < 2; d++) begin
      if (m_cap[d] && m_pix[d] < m_max[d]) begin
        if (d == 0) q_a.push_back({15'(m_pix[d]), to332(p)});
        else        q_b.push_back({15'(m_pix[d]), to332(p)});
        m_pix[d]++;
        if (m_pix[d] == m_max[d]) begin
          m_cap[d]  = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_wait[d] = 1'b0; m_cap[d] = 1'b0; m_done[d] = 1'b0;
      m_pix[d] = 0; m_lines[d] = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit to_a, input bit to_b, input bit we,
                     input logic [31:0] adr, input logic [31:0] dat, input bit sel,
                     output logic [31:0] rd_a, output logic [31:0] rd_b, output int lat);
    lat = -1;
    wb_a.wb_adr_i = adr; wb_a.wb_dat_i = dat; wb_a.wb_we_i = we; wb_a.wb_sel_i = sel;
    wb_b.wb_adr_i = adr; wb_b.wb_dat_i = dat; wb_b.wb_we_i = we; wb_b.wb_sel_i = sel;
    wb_a.wb_cyc_i = to_a; wb_a.wb_stb_i = to_a;
    wb_b.wb_cyc_i = to_b; wb_b.wb_stb_i = to_b;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if ((to_a && wb_a.wb_ack_o) || (!to_a && wb_b.wb_ack_o)) begin
        lat = i;
        break;
      end
    end
    rd_a = wb_a.wb_dat_o;
    rd_b = wb_b.wb_dat_o;
    wb_a.wb_cyc_i = 1'b0; wb_a.wb_stb_i = 1'b0; wb_a.wb_we_i = 1'b0;
    wb_b.wb_cyc_i = 1'b0; wb_b.wb_stb_i = 1'b0; wb_b.wb_we_i = 1'b0;
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL bus_ack_timeout: got no ack, expected ack within 8 cycles (adr 0x%0h)", adr);
    end
    clks(1);
  endtask

  logic [31:0] ra, rb;
  int          lat;

  task automatic rd(input logic [31:0] adr);
    bus(1'b1, 1'b1, 1'b0, adr, 32'h0, 1'b1, ra, rb, lat);
  endtask

  task automatic wr(input bit to_a, input bit to_b, input logic [31:0] adr,
                    input logic [31:0] dat, input bit sel);
    logic [31:0] xa, xb;
    int          xl;
    bus(to_a, to_b, 1'b1, adr, dat, sel, xa, xb, xl);
    if (sel && adr == 32'h4 && dat[0]) begin
      if (to_a) m_start(0);
      if (to_b) m_start(1);
    end
  endtask

  task automatic cam_byte(input logic [7:0] b, input bit second, input logic [15:0] p);
    cam_data = b;
    clks(4);
    pclk = 1'b1;
    if (second) m_pixel(p);
    clks(4);
    pclk = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] p);
    cam_byte(p[15:8], 1'b0, p);
    cam_byte(p[7:0], 1'b1, p);
  endtask

  task automatic line_start();
    href = 1'b1;
    clks(4);
  endtask

  task automatic line_end();
    clks(4);
    href = 1'b0;
    for (int d = 0; d < 2; d++) if (m_cap[d]) m_lines[d]++;
    clks(8);
  endtask

  task automatic vs_fall();
    vsync = 1'b0;
    for (int d = 0; d < 2; d++)
      if (m_wait[d]) begin m_wait[d] = 1'b0; m_cap[d] = 1'b1; end
    clks(8);
  endtask

  task automatic vs_rise();
    vsync = 1'b1;
    for (int d = 0; d < 2; d++)
      if (m_cap[d]) begin m_cap[d] = 1'b0; m_done[d] = 1'b1; end
    clks(8);
  endtask

  task automatic check_regs(input string tag);
    rd(32'h0);
    chk({tag, "_status_a"}, ra, exp_status(0));
    chk({tag, "_status_b"}, rb, exp_status(1));
    rd(32'h8);
    chk({tag, "_pixcnt_a"}, ra, 32'(m_pix[0]));
    chk({tag, "_pixcnt_b"}, rb, 32'(m_pix[1]));
    rd(32'hC);
    chk({tag, "_linecnt_a"}, ra, 32'(m_lines[0]));
    chk({tag, "_linecnt_b"}, rb, 32'(m_lines[1]));
    chk({tag, "_done_a"}, 32'(done_a), 32'(m_done[0]));
    chk({tag, "_done_b"}, 32'(done_b), 32'(m_done[1]));
  endtask

  // ---------------- per-cycle compare ----------------
  logic [22:0] e_a, e_b;
  logic [14:0] last_addr_a;
  logic [7:0]  last_data_a;
  int          n_wr_a = 0;
  int          n_wr_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_outputs_a", 32'({we_a, done_a, wb_a.wb_ack_o, |wb_a.wb_dat_o, |addr_a, |data_a}), 32'h0);
      chk("rst_outputs_b", 32'({we_b, done_b, wb_b.wb_ack_o, |wb_b.wb_dat_o, |addr_b, |data_b}), 32'h0);
    end else begin
      if (we_a === 1'b1) begin
        if (q_a.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_we_a: got write addr 0x%0h data 0x%0h, expected no write", addr_a, data_a);
        end else begin
          e_a = q_a.pop_front();
          chk("wr_addr_a", 32'(addr_a), 32'(e_a[22:8]));
          chk("wr_data_a", 32'(data_a), 32'(e_a[7:0]));
          last_addr_a = addr_a;
          last_data_a = data_a;
          n_wr_a++;
        end
      end
      if (we_b === 1'b1) begin
        if (q_b.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_we_b: got write addr 0x%0h data 0x%0h, expected no write", addr_b, data_b);
        end else begin
          e_b = q_b.pop_front();
          chk("wr_addr_b", 32'(addr_b), 32'(e_b[22:8]));
          chk("wr_data_b", 32'(data_b), 32'(e_b[7:0]));
          n_wr_b++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic [15:0] pat [6] = '{16'hF800, 16'h1234, 16'hA55A, 16'h0718, 16'hE3FF, 16'h4C93};
  bit          ack_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    wb_a.wb_adr_i = '0; wb_a.wb_dat_i = '0; wb_a.wb_we_i = 1'b0;
    wb_a.wb_cyc_i = 1'b0; wb_a.wb_stb_i = 1'b0; wb_a.wb_sel_i = 1'b0;
    wb_b.wb_adr_i = '0; wb_b.wb_dat_i = '0; wb_b.wb_we_i = 1'b0;
    wb_b.wb_cyc_i = 1'b0; wb_b.wb_stb_i = 1'b0; wb_b.wb_sel_i = 1'b0;
    m_reset();

    // Reset
    rst = 1'b0;
    clks(20);
    rst = 1'b1;
    clks(3);
    chk("post_rst_mem_we_a", 32'(we_a), 32'h0);
    chk("post_rst_done_a", 32'(done_a), 32'h0);
    rd(32'h0);
    chk("rst_status_a", ra, 32'h0);
    chk("rst_status_b", rb, exp_status(1));
    chk("ack_latency", 32'(lat), 32'd1);

    // Held strobe: ack toggles every cycle, read data of STATUS is 0
    wb_a.wb_adr_i = 32'h0; wb_a.wb_we_i = 1'b0;
    wb_a.wb_cyc_i = 1'b1; wb_a.wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("held_stb_ack", 32'(wb_a.wb_ack_o), 32'(ack_pat[i]));
    end
    chk("held_stb_dat", wb_a.wb_dat_o, 32'h0);
    wb_a.wb_cyc_i = 1'b0; wb_a.wb_stb_i = 1'b0;
    clks(2);

    rd(32'h4);
    chk("ctrl_reads_zero_a", ra, 32'h0);

    // Masked start write has no effect
    wr(1'b1, 1'b1, 32'h4, 32'h1, 1'b0);
    rd(32'h0);
    chk("masked_status_a", ra, 32'h0);
    chk("masked_status_b", rb, exp_status(1));

    // Frame 1: two lines of four 0xF800 pixels
    wr(1'b1, 1'b1, 32'h4, 32'h1, 1'b1);
    rd(32'h0);
    chk("start_status_a", ra, 32'h1);
    chk("start_status_b", rb, exp_status(1));
    vs_fall();
    line_start();
    for (int i = 0; i < 4; i++) send_pixel(16'hF800);
    line_end();
    wr(1'b1, 1'b0, 32'h4, 32'h1, 1'b1);   // start while busy: ignored
    rd(32'h8);
    chk("busy_start_pixcnt_a", ra, 32'(m_pix[0]));
    line_start();
    for (int i = 0; i < 4; i++) send_pixel(16'hF800);
    line_end();
    vs_rise();
    check_regs("frame1");
    rd(32'h0);
    chk("frame1_status_lit_a", ra, 32'h2);
    rd(32'h8);
    chk("frame1_pixcnt_lit_a", ra, 32'd8);
    chk("frame1_pixcnt_lit_b", rb, 32'd4);
    rd(32'hC);
    chk("frame1_linecnt_lit_a", ra, 32'd2);
    chk("frame1_done_lit_a", 32'(done_a), 32'h1);
    chk("frame1_last_addr_a", 32'(last_addr_a), 32'd7);
    chk("frame1_last_data_a", 32'(last_data_a), 32'hE0);
    chk("frame1_nwr_a", 32'(n_wr_a), 32'd8);
    chk("frame1_nwr_b", 32'(n_wr_b), 32'd4);

    // Frame 2: restart from DONE, six mixed pixels (limit hits on B)
    wr(1'b1, 1'b1, 32'h4, 32'h1, 1'b1);
    check_regs("restart");
    vs_fall();
    line_start();
    for (int i = 0; i < 6; i++) send_pixel(pat[i]);
    line_end();
    vs_rise();
    check_regs("frame2");
    chk("frame2_nwr_b", 32'(n_wr_b), 32'd8);
    chk("frame2_qa_empty", 32'(q_a.size()), 32'd0);
    chk("frame2_qb_empty", 32'(q_b.size()), 32'd0);

    // Frame 3: reset asserted in the middle of a capture
    wr(1'b1, 1'b1, 32'h4, 32'h1, 1'b1);
    vs_fall();
    line_start();
    send_pixel(pat[1]);
    send_pixel(pat[2]);
    clks(10);
    chk("pre_rst_qa_empty", 32'(q_a.size()), 32'd0);
    chk("pre_rst_qb_empty", 32'(q_b.size()), 32'd0);
    rst = 1'b0;
    m_reset();
    clks(5);
    rst = 1'b1;
    clks(2);
    send_pixel(pat[3]);
    send_pixel(pat[4]);
    line_end();
    vs_rise();
    check_regs("midrst");
    rd(32'h0);
    chk("midrst_status_lit_a", ra, 32'h0);

    clks(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
